mempool_boot_ctrl: RTL and testbench

//  Synthesizable boot/run controller for a MemPool cluster with NumCores cores. It holds

---
 rtl/mempool_boot_ctrl.sv | 154 +++++++++++++++
 tb/tb_mempool_boot_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mempool_boot_ctrl.sv
// Boot/run controller for a MemPool cluster: holds all cores in reset, releases them
// in a staggered order, then watches the busy flags until the cluster is idle or out of budget.
module mempool_boot_ctrl #(
    parameter int unsigned NumCores      = 16,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned ResetCycles   = 5,
    parameter int unsigned StaggerCycles = 1,
    parameter int unsigned CntWidth      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] boot_addr_i,
    input  logic [CntWidth-1:0]  timeout_i,
    input  logic [NumCores-1:0]  core_busy_i,
    output logic [NumCores-1:0]  core_rst_no,
    output logic [NumCores-1:0]  fetch_en_o,
    output logic [AddrWidth-1:0] boot_addr_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [CntWidth-1:0]  cycle_cnt_o
);

    localparam int unsigned HoldW = (ResetCycles > 1) ? $clog2(ResetCycles) : 1;
    localparam int unsigned StagW = (StaggerCycles > 1) ? $clog2(StaggerCycles) : 1;
    localparam int unsigned IdxW  = (NumCores > 1) ? $clog2(NumCores) : 1;

    localparam logic [HoldW-1:0] HoldLast = HoldW'(ResetCycles - 1);
    localparam logic [StagW-1:0] StagLast = StagW'(StaggerCycles - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NumCores - 1);

    typedef enum logic [2:0] {
        IDLE, HOLD, RELEASE, RUN, DONE, TIMEOUT
    } state_e;

    state_e               state, state_nxt;
    logic [HoldW-1:0]     hold_cnt, hold_cnt_nxt;
    logic [StagW-1:0]     stag_cnt, stag_cnt_nxt;
    logic [IdxW-1:0]      idx, idx_nxt;
    logic                 idle_seen, idle_seen_nxt;
    logic [CntWidth-1:0]  budget, budget_nxt;
    logic [NumCores-1:0]  core_rst_nxt, fetch_en_nxt;
    logic [AddrWidth-1:0] boot_addr_nxt;
    logic                 done_nxt, timeout_nxt;
    logic [CntWidth-1:0]  cycle_cnt_nxt, cnt_inc;
    logic [NumCores-1:0]  next_bit;
    logic                 all_idle;

    assign cnt_inc  = (cycle_cnt_o == '1) ? cycle_cnt_o : cycle_cnt_o + 1'b1;
    assign next_bit = NumCores'(1) << (idx + 1'b1);
    assign all_idle = (core_busy_i == '0);

    always_comb begin
        state_nxt     = state;
        hold_cnt_nxt  = hold_cnt;
        stag_cnt_nxt  = stag_cnt;
        idx_nxt       = idx;
        idle_seen_nxt = idle_seen;
        budget_nxt    = budget;
        core_rst_nxt  = core_rst_no;
        fetch_en_nxt  = fetch_en_o;
        boot_addr_nxt = boot_addr_o;
        done_nxt      = done_o;
        timeout_nxt   = timeout_o;
        cycle_cnt_nxt = cycle_cnt_o;

        case (state)
            IDLE, DONE, TIMEOUT: begin
                if (start_i) begin
                    state_nxt     = HOLD;
                    boot_addr_nxt = boot_addr_i;
                    budget_nxt    = timeout_i;
                    done_nxt      = 1'b0;
                    timeout_nxt   = 1'b0;
                    cycle_cnt_nxt = '0;
                    core_rst_nxt  = '0;
                    fetch_en_nxt  = '0;
                    hold_cnt_nxt  = '0;
                    idle_seen_nxt = 1'b0;
                end
            end
            HOLD: begin
                if (hold_cnt == HoldLast) begin
                    state_nxt       = RELEASE;
                    idx_nxt         = '0;
                    stag_cnt_nxt    = '0;
                    core_rst_nxt[0] = 1'b1;
                    fetch_en_nxt[0] = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            RELEASE: begin
                // The last core was released on the previous edge; this cycle is the one after.
                if (idx == IdxLast) begin
                    state_nxt = RUN;
                end else if (stag_cnt == StagLast) begin
                    stag_cnt_nxt = '0;
                    idx_nxt      = idx + 1'b1;
                    core_rst_nxt = core_rst_no | next_bit;
                    fetch_en_nxt = fetch_en_o | next_bit;
                end else begin
                    stag_cnt_nxt = stag_cnt + 1'b1;
                end
            end
            RUN: begin
                cycle_cnt_nxt = cnt_inc;
                idle_seen_nxt = all_idle;
                // Idle completion is checked first so it wins a same-cycle budget expiry.
                if (all_idle && idle_seen) begin
                    state_nxt    = DONE;
                    done_nxt     = 1'b1;
                    fetch_en_nxt = '0;
                end else if (budget != '0 && cnt_inc == budget) begin
                    state_nxt    = TIMEOUT;
                    timeout_nxt  = 1'b1;
                    fetch_en_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            stag_cnt    <= '0;
            idx         <= '0;
            idle_seen   <= 1'b0;
            budget      <= '0;
            core_rst_no <= '0;
            fetch_en_o  <= '0;
            boot_addr_o <= '0;
            done_o      <= 1'b0;
            timeout_o   <= 1'b0;
            cycle_cnt_o <= '0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_cnt_nxt;
            stag_cnt    <= stag_cnt_nxt;
            idx         <= idx_nxt;
            idle_seen   <= idle_seen_nxt;
            budget      <= budget_nxt;
            core_rst_no <= core_rst_nxt;
            fetch_en_o  <= fetch_en_nxt;
            boot_addr_o <= boot_addr_nxt;
            done_o      <= done_nxt;
            timeout_o   <= timeout_nxt;
            cycle_cnt_o <= cycle_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mempool_boot_ctrl.sv
// Bench for mempool_boot_ctrl: release schedule and run outcome are predicted from
// the boot timeline (hold, stagger, busy history) rather than from the controller's states.
module tb_mempool_boot_ctrl;

    localparam int N = 4, R = 5, S = 2;
    localparam int L = R + S * (N - 1);     // cycle offset of the last release edge
    localparam int N2 = 2, R2 = 3, S2 = 1;
    localparam int L2 = R2 + S2 * (N2 - 1);

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic [31:0] boot_addr, timeout, boot_addr_q;
    logic [N-1:0] busy, rst_n, fetch;
    logic        done, to;
    logic [31:0] cnt;

    logic [7:0]  boot_addr2, boot_addr2_q;
    logic [3:0]  timeout2, cnt2;
    logic [N2-1:0] busy2, rst_n2, fetch2;
    logic        done2, to2;

    logic [3:0]  bseq [0:63];
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    mempool_boot_ctrl #(.NumCores(N), .AddrWidth(32), .ResetCycles(R),
                        .StaggerCycles(S), .CntWidth(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .boot_addr_i(boot_addr),
        .timeout_i(timeout), .core_busy_i(busy), .core_rst_no(rst_n),
        .fetch_en_o(fetch), .boot_addr_o(boot_addr_q), .done_o(done),
        .timeout_o(to), .cycle_cnt_o(cnt));

    mempool_boot_ctrl #(.NumCores(N2), .AddrWidth(8), .ResetCycles(R2),
                        .StaggerCycles(S2), .CntWidth(4)) dut_sat (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .boot_addr_i(boot_addr2),
        .timeout_i(timeout2), .core_busy_i(busy2), .core_rst_no(rst_n2),
        .fetch_en_o(fetch2), .boot_addr_o(boot_addr2_q), .done_o(done2),
        .timeout_o(to2), .cycle_cnt_o(cnt2));

    task automatic test_reset();
        logic [N-1:0] exp_rst;
        rst = 1'b1; start = 0; start2 = 0; busy = '0; busy2 = '0;
        boot_addr = '0; timeout = '0; boot_addr2 = '0; timeout2 = '0;
        #12;
        n_cmp++;
        if ({rst_n, fetch, boot_addr_q, done, to, cnt} !== '0) begin
            n_err++; $display("FAIL reset_init got rst=%b fen=%b addr=%h d=%b t=%b cnt=%0d exp all 0",
                              rst_n, fetch, boot_addr_q, done, to, cnt);
        end
        @(negedge clk); rst = 1'b0;
        // Boot and abort mid-release.
        @(negedge clk); start = 1; boot_addr = 32'h1234_5678; timeout = 0;
        @(negedge clk); start = 0;
        for (int j = 0; j < R + S; j++) begin
            busy = N'($urandom);
            @(negedge clk);
        end
        exp_rst = '0;
        for (int k = 0; k < N; k++) if (R + S >= R + S * k) exp_rst[k] = 1'b1;
        n_cmp++;
        if (rst_n !== exp_rst) begin
            n_err++; $display("FAIL reset_prerelease got %b exp %b", rst_n, exp_rst);
        end
        rst = 1'b1; #1;
        n_cmp++;
        if ({rst_n, fetch, boot_addr_q, done, to, cnt} !== '0) begin
            n_err++; $display("FAIL reset_abort got rst=%b fen=%b addr=%h d=%b t=%b cnt=%0d exp all 0",
                              rst_n, fetch, boot_addr_q, done, to, cnt);
        end
        @(negedge clk); rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            busy = N'($urandom);
            @(negedge clk);
            n_cmp++;
            if ({rst_n, fetch, boot_addr_q, done, to, cnt} !== '0) begin
                n_err++; $display("FAIL reset_idle j=%0d got rst=%b fen=%b cnt=%0d exp all 0",
                                  j, rst_n, fetch, cnt);
            end
        end
    endtask

    // Boots the main DUT with busy history bseq[] (bseq[n-1] = busy in RUN cycle n).
    task automatic run_boot(input string name, input logic [31:0] addr,
                            input logic [31:0] budget, input bit start_in_run);
        int exp_end, kind, nrun, n;
        logic [N-1:0] exp_rst, exp_fetch;
        logic [31:0]  exp_cnt;
        exp_end = 0; kind = 0;
        for (int i = 1; i <= 64; i++) begin
            if (i >= 2 && bseq[i-1] == 4'd0 && bseq[i-2] == 4'd0) begin
                exp_end = i; kind = 1; break;
            end
            if (budget != 0 && i == budget) begin
                exp_end = i; kind = 2; break;
            end
        end
        @(negedge clk); start = 1; boot_addr = addr; timeout = budget; busy = N'($urandom);
        @(negedge clk); start = 0; boot_addr = $urandom; timeout = $urandom;
        for (int j = 0; j <= L + 3 + exp_end; j++) begin
            nrun = j - (L + 1);
            exp_rst = '0;
            for (int k = 0; k < N; k++) if (j >= R + S * k) exp_rst[k] = 1'b1;
            exp_fetch = (nrun >= exp_end) ? '0 : exp_rst;
            exp_cnt = (nrun <= 0) ? 0 : (nrun > exp_end ? exp_end : nrun);
            n_cmp++;
            if (rst_n !== exp_rst) begin
                n_err++; $display("FAIL %s core_rst_no j=%0d got %b exp %b", name, j, rst_n, exp_rst);
            end
            n_cmp++;
            if (fetch !== exp_fetch) begin
                n_err++; $display("FAIL %s fetch_en j=%0d got %b exp %b", name, j, fetch, exp_fetch);
            end
            n_cmp++;
            if (cnt !== exp_cnt) begin
                n_err++; $display("FAIL %s cycle_cnt j=%0d got %0d exp %0d", name, j, cnt, exp_cnt);
            end
            n_cmp++;
            if (done !== (kind == 1 && nrun >= exp_end) || to !== (kind == 2 && nrun >= exp_end)) begin
                n_err++; $display("FAIL %s flags j=%0d got done=%b to=%b exp done=%b to=%b", name, j,
                                  done, to, kind == 1 && nrun >= exp_end, kind == 2 && nrun >= exp_end);
            end
            n_cmp++;
            if (boot_addr_q !== addr) begin
                n_err++; $display("FAIL %s boot_addr j=%0d got %h exp %h", name, j, boot_addr_q, addr);
            end
            n = j + 1 - (L + 1);
            busy = (n >= 1 && n <= 64) ? bseq[n-1] : N'($urandom);
            if (start_in_run && n == 3) begin
                start = 1; boot_addr = ~addr; timeout = 32'd2;
            end else begin
                start = 0;
            end
            @(negedge clk);
        end
        start = 0;
    endtask

    task automatic test_boot_done();
        for (int i = 0; i < 64; i++) bseq[i] = (i < 20) ? 4'b1111 : 4'b0000;
        run_boot("boot_done", 32'h8000_0000, 32'd0, 1'b0);
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 64; i++) bseq[i] = 4'b1111;
        run_boot("timeout", 32'h0000_4000, 32'd10, 1'b0);
    endtask

    task automatic test_collision();
        for (int i = 0; i < 64; i++) bseq[i] = (i < 5) ? 4'($urandom_range(1, 15)) : 4'b0000;
        run_boot("collision", 32'hCAFE_0000, 32'd7, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 64; i++)
                bseq[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            run_boot("random", $urandom, 32'($urandom_range(3, 40)), 1'b0);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_cnt;
        @(negedge clk); start2 = 1; boot_addr2 = 8'hA5; timeout2 = 4'd0; busy2 = 2'b11;
        @(negedge clk); start2 = 0;
        for (int j = 0; j < L2 + 30; j++) begin
            exp_cnt = (j <= L2 + 1) ? 4'd0 : ((j - (L2 + 1)) > 15 ? 4'd15 : 4'(j - (L2 + 1)));
            n_cmp++;
            if (cnt2 !== exp_cnt || done2 !== 1'b0 || to2 !== 1'b0) begin
                n_err++; $display("FAIL saturation j=%0d got cnt=%0d d=%b t=%b exp cnt=%0d d=0 t=0",
                                  j, cnt2, done2, to2, exp_cnt);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (rst_n2 !== 2'b11 || fetch2 !== 2'b11 || boot_addr2_q !== 8'hA5) begin
            n_err++; $display("FAIL saturation_outputs got rst=%b fen=%b addr=%h exp 11 11 a5",
                              rst_n2, fetch2, boot_addr2_q);
        end
    endtask

    initial begin
        test_reset();
        test_boot_done();
        test_timeout();
        test_collision();
        test_back_to_back();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
